icache_miss_handler: RTL and testbench

//  Miss-fill controller for the direct-mapped L1 instruction cache; the producer of ICACHE_busy consumed by the hazard unit.
//  On a miss it latches the block address, issues pipelined word reads to main memory and writes returned words into the data array.
//  It writes the tag once the block is complete and holds fsm_busy high so PC and IF/ID stall for the whole fill.

---
 rtl/icache_pkg.sv | 14 +
 rtl/icache_word_counter.sv | 38 +++
 rtl/icache_miss_handler.sv | 160 ++++++++++++++++
 tb/tb_icache_miss_handler.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared types and geometry for the L1 instruction-cache miss handler.
// Purely declarative: no logic and no latency.
package icache_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_e;

    localparam int WORDS_PER_BLOCK = 8;
    localparam int BLOCK_OFFSET_W  = 4;
    localparam int WORD_IDX_W      = 3;

endpackage

// File: rtl/icache_word_counter.sv
// Saturating up-counter with synchronous clear; clear wins over enable.
// Latency: count updates one cycle after clr/en. Backpressure: none, holds at MAX.
module icache_word_counter #(
    parameter int W   = 4,
    parameter int MAX = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && (count_q < MAX_V)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/icache_miss_handler.sv
// Miss-fill controller: latches the missing block, issues one word read per cycle, writes returns, tags last.
// Latency: busy rises combinationally with the miss; tag written with the final returned word.
// Backpressure: stalls fetch via fsm_busy; ICACHE_PERF_CNT_EN adds miss/stall counters.
module icache_miss_handler #(
    parameter int ADDR_W          = 16,
    parameter int WORDS_PER_BLOCK = icache_pkg::WORDS_PER_BLOCK
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               miss_detected,
    input  logic [ADDR_W-1:0]                  miss_address,
    input  logic                               memory_data_valid,
    input  logic [15:0]                        memory_data,
    output logic                               fsm_busy,
    output logic                               mem_en,
    output logic [ADDR_W-1:0]                  memory_address,
    output logic                               write_data_array,
    output logic [$clog2(WORDS_PER_BLOCK)-1:0] write_word_idx,
    output logic [15:0]                        fill_data,
    output logic                               write_tag_array
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [15:0]                        miss_count,
    output logic [31:0]                        stall_cycles
`endif
);

    import icache_pkg::*;

    localparam int IDX_W = $clog2(WORDS_PER_BLOCK);
    localparam int OFF_W = IDX_W + 1;
    localparam int CNT_W = IDX_W + 1;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORDS_PER_BLOCK);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORDS_PER_BLOCK - 1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   blk_base_q, blk_base_d;

    logic                issue_clr, issue_en;
    logic                recv_clr, recv_en;
    logic [CNT_W-1:0]    issue_cnt;
    logic [CNT_W-1:0]    recv_cnt;

    wire unused_offset_bits = ^miss_address[OFF_W-1:0];

    icache_word_counter #(
        .W   (CNT_W),
        .MAX (WORDS_PER_BLOCK)
    ) u_issue_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (issue_clr),
        .en    (issue_en),
        .count (issue_cnt)
    );

    icache_word_counter #(
        .W   (CNT_W),
        .MAX (WORDS_PER_BLOCK)
    ) u_recv_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (recv_clr),
        .en    (recv_en),
        .count (recv_cnt)
    );

    always_comb begin
        state_d          = state_q;
        blk_base_d       = blk_base_q;
        issue_clr        = 1'b0;
        issue_en         = 1'b0;
        recv_clr         = 1'b0;
        recv_en          = 1'b0;
        fsm_busy         = 1'b0;
        mem_en           = 1'b0;
        memory_address   = '0;
        write_data_array = 1'b0;
        write_word_idx   = '0;
        fill_data        = '0;
        write_tag_array  = 1'b0;

        // Outputs are forced quiet while reset is held so a reset that lands on the
        // final return cannot tag a block whose fill is being abandoned.
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    fsm_busy = miss_detected;
                    if (miss_detected) begin
                        blk_base_d = {miss_address[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        issue_clr  = 1'b1;
                        recv_clr   = 1'b1;
                        state_d    = FILL;
                    end
                end
                FILL: begin
                    fsm_busy = 1'b1;
                    if (issue_cnt < CNT_FULL) begin
                        mem_en         = 1'b1;
                        issue_en       = 1'b1;
                        memory_address = blk_base_q
                                       + {{(ADDR_W-CNT_W-1){1'b0}}, issue_cnt, 1'b0};
                    end
                    if (memory_data_valid) begin
                        write_data_array = 1'b1;
                        write_word_idx   = recv_cnt[IDX_W-1:0];
                        fill_data        = memory_data;
                        recv_en          = 1'b1;
                        if (recv_cnt == CNT_LAST) begin
                            write_tag_array = 1'b1;
                            state_d         = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            blk_base_q <= '0;
        end else begin
            state_q    <= state_d;
            blk_base_q <= blk_base_d;
        end
    end

`ifdef ICACHE_PERF_CNT_EN
    logic [15:0] miss_count_q, miss_count_d;
    logic [31:0] stall_cycles_q, stall_cycles_d;

    always_comb begin
        miss_count_d   = miss_count_q;
        stall_cycles_d = stall_cycles_q;
        if ((state_q == IDLE) && (state_d == FILL) && (miss_count_q != 16'hFFFF)) begin
            miss_count_d = miss_count_q + 16'd1;
        end
        if (fsm_busy) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            miss_count_q   <= '0;
            stall_cycles_q <= '0;
        end else begin
            miss_count_q   <= miss_count_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign miss_count   = miss_count_q;
    assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_icache_miss_handler.sv
// Directed bench for icache_miss_handler: per-cycle vector table for a basic fill plus
// hand-written sequences for gapped returns, mid-fill disturbance, reset and stray returns.
module tb_icache_miss_handler;

    logic        clk = 1'b0;
    logic        rst;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic        memory_data_valid;
    logic [15:0] memory_data;
    logic        fsm_busy;
    logic        mem_en;
    logic [15:0] memory_address;
    logic        write_data_array;
    logic [2:0]  write_word_idx;
    logic [15:0] fill_data;
    logic        write_tag_array;
`ifdef ICACHE_PERF_CNT_EN
    logic [15:0] miss_count;
    logic [31:0] stall_cycles;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    icache_miss_handler dut (
        .clk               (clk),
        .rst               (rst),
        .miss_detected     (miss_detected),
        .miss_address      (miss_address),
        .memory_data_valid (memory_data_valid),
        .memory_data       (memory_data),
        .fsm_busy          (fsm_busy),
        .mem_en            (mem_en),
        .memory_address    (memory_address),
        .write_data_array  (write_data_array),
        .write_word_idx    (write_word_idx),
        .fill_data         (fill_data),
        .write_tag_array   (write_tag_array)
`ifdef ICACHE_PERF_CNT_EN
        ,
        .miss_count        (miss_count),
        .stall_cycles      (stall_cycles)
`endif
    );

    typedef struct {
        logic        miss;
        logic [15:0] addr;
        logic        mv;
        logic [15:0] md;
        logic        busy;
        logic        men;
        logic [15:0] maddr;
        logic        wr;
        logic [2:0]  idx;
        logic [15:0] fd;
        logic        tag;
    } vec_t;

    vec_t tv[13];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Address/idx/data are only meaningful when their qualifier is high.
    function automatic logic [38:0] obs();
        return {fsm_busy, mem_en, mem_en ? memory_address : 16'h0,
                write_data_array, write_data_array ? write_word_idx : 3'd0,
                write_data_array ? fill_data : 16'h0, write_tag_array};
    endfunction

    function automatic logic [38:0] raw();
        return {fsm_busy, mem_en, memory_address, write_data_array,
                write_word_idx, fill_data, write_tag_array};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        miss_detected     = 1'b0;
        memory_data_valid = 1'b0;
        memory_data       = 16'h0;
    endtask

    task automatic idle_chk(input string nm);
        idle_inputs();
        #4;
        chk(nm, obs(), 39'h0);
        tick();
    endtask

    // Full fill starting with a one-cycle miss in cycle 0; returns arrive from cycle 4
    // every 'gap' cycles. 'disturb' moves miss_address and re-asserts miss mid-fill.
    task automatic fill_seq(input string nm, input logic [15:0] addr, input int gap, input bit disturb);
        logic [15:0] base;
        logic [15:0] d;
        logic [15:0] exp_addr;
        bit          v;
        bit          exp_men;
        bit          done;
        int          recvd;
        int          c;
        base  = {addr[15:4], 4'h0};
        recvd = 0;
        done  = 1'b0;
        c     = 0;
        while (!done && c < 40) begin
            miss_detected     = (c == 0) || (disturb && c == 3);
            miss_address      = (disturb && c >= 2) ? 16'hFFF0 : addr;
            v                 = (c >= 4) && (((c - 4) % gap) == 0) && (recvd < 8);
            d                 = v ? (16'hC000 + 16'(c)) : 16'h0;
            memory_data_valid = v;
            memory_data       = d;
            exp_men           = (c >= 1) && (c <= 8);
            exp_addr          = exp_men ? (base + 16'(2 * (c - 1))) : 16'h0;
            #4;
            chk($sformatf("%s_c%0d", nm, c), obs(),
                {1'b1, exp_men, exp_addr, v, v ? 3'(recvd) : 3'd0, d, v && (recvd == 7)});
            if (v) begin
                if (recvd == 7) done = 1'b1;
                recvd++;
            end
            tick();
            c++;
        end
        idle_inputs();
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: got %0d words required 8", nm, recvd);
        end
    endtask

    initial begin
        rst               = 1'b1;
        miss_address      = 16'h0;
        idle_inputs();

        tv[0]  = '{1'b1, 16'h1236, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0};
        tv[1]  = '{1'b0, 16'h1236, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h1230, 1'b0, 3'd0, 16'h0000, 1'b0};
        tv[2]  = '{1'b0, 16'h1236, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h1232, 1'b0, 3'd0, 16'h0000, 1'b0};
        tv[3]  = '{1'b0, 16'h1236, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h1234, 1'b0, 3'd0, 16'h0000, 1'b0};
        tv[4]  = '{1'b0, 16'h1236, 1'b1, 16'hA000, 1'b1, 1'b1, 16'h1236, 1'b1, 3'd0, 16'hA000, 1'b0};
        tv[5]  = '{1'b0, 16'h1236, 1'b1, 16'hA001, 1'b1, 1'b1, 16'h1238, 1'b1, 3'd1, 16'hA001, 1'b0};
        tv[6]  = '{1'b0, 16'h1236, 1'b1, 16'hA002, 1'b1, 1'b1, 16'h123A, 1'b1, 3'd2, 16'hA002, 1'b0};
        tv[7]  = '{1'b0, 16'h1236, 1'b1, 16'hA003, 1'b1, 1'b1, 16'h123C, 1'b1, 3'd3, 16'hA003, 1'b0};
        tv[8]  = '{1'b0, 16'h1236, 1'b1, 16'hA004, 1'b1, 1'b1, 16'h123E, 1'b1, 3'd4, 16'hA004, 1'b0};
        tv[9]  = '{1'b0, 16'h1236, 1'b1, 16'hA005, 1'b1, 1'b0, 16'h0000, 1'b1, 3'd5, 16'hA005, 1'b0};
        tv[10] = '{1'b0, 16'h1236, 1'b1, 16'hA006, 1'b1, 1'b0, 16'h0000, 1'b1, 3'd6, 16'hA006, 1'b0};
        tv[11] = '{1'b0, 16'h1236, 1'b1, 16'hA007, 1'b1, 1'b0, 16'h0000, 1'b1, 3'd7, 16'hA007, 1'b1};
        tv[12] = '{1'b0, 16'h1236, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0};

        tick();
        tick();
        rst = 1'b0;
        #4;
        chk("reset_outputs", raw(), 39'h0);
`ifdef ICACHE_PERF_CNT_EN
        chk("reset_perf", {miss_count, stall_cycles}, 48'h0);
`endif
        tick();

        for (int i = 0; i < 13; i++) begin
            miss_detected     = tv[i].miss;
            miss_address      = tv[i].addr;
            memory_data_valid = tv[i].mv;
            memory_data       = tv[i].md;
            #4;
            chk($sformatf("t1_row%0d", i), obs(),
                {tv[i].busy, tv[i].men, tv[i].maddr, tv[i].wr, tv[i].idx, tv[i].fd, tv[i].tag});
            tick();
        end
        idle_inputs();

        fill_seq("t2_gap", 16'h2000, 2, 1'b0);
        idle_chk("t2_idle");

        fill_seq("t3_disturb", 16'h7A5C, 1, 1'b1);
        idle_chk("t3_idle");

        miss_detected = 1'b1;
        miss_address  = 16'h3000;
        tick();
        miss_detected = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            memory_data_valid = (c >= 4);
            memory_data       = 16'hD000 + 16'(c);
            #4;
            if (c >= 4) begin
                chk($sformatf("t4_pre_wr%0d", c),
                    {write_data_array, write_word_idx, write_tag_array}, {1'b1, 3'(c - 4), 1'b0});
            end
            tick();
        end
        rst               = 1'b1;
        memory_data_valid = 1'b0;
        tick();
        rst = 1'b0;
        #4;
        chk("t4_after_rst", raw(), 39'h0);
        tick();

        for (int k = 0; k < 3; k++) begin
            memory_data_valid = 1'b1;
            memory_data       = 16'hBEEF;
            #4;
            chk($sformatf("t5_stray%0d", k),
                {fsm_busy, mem_en, write_data_array, write_tag_array}, 4'h0);
            tick();
        end
        idle_inputs();

        fill_seq("t4_refill", 16'h0040, 1, 1'b0);
        idle_chk("t4_idle");

`ifdef ICACHE_PERF_CNT_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        fill_seq("t6_fill_a", 16'h4000, 1, 1'b0);
        fill_seq("t6_fill_b", 16'h5010, 1, 1'b0);
        idle_chk("t6_idle");
        chk("t6_miss_count", miss_count, 64'd2);
        chk("t6_stall_cycles", stall_cycles, 64'd24);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
